single_wire_dht_rx: RTL

SINGLE_WIRE_DHT_RX -- requirements
Module: single_wire_dht_rx

---
 rtl/single_wire_dht_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/single_wire_dht_rx.sv
// rtl/single_wire_dht_rx.sv - single-wire (DHT11/DHT22-style) sensor frame receiver
module single_wire_dht_rx #(
    parameter int CLK_MHZ       = 24,
    parameter int START_LOW_US  = 20000,
    parameter int DATA_BITS     = 40,
    parameter int ONE_THRESH_US = 40,
    parameter int CHECKSUM_EN   = 1,
    parameter int HOLDOFF_US    = 1000000,
    parameter int T_RESP_US     = 50,
    parameter int T_ACK_US      = 100,
    parameter int T_BITLOW_US   = 60,
    parameter int T_BITHIGH_US  = 80
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 wire_in,
    output logic                 wire_oe,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic [2:0]           err,
    output logic [DATA_BITS-1:0] out_data
);

    localparam int START_CYC   = START_LOW_US * CLK_MHZ;
    localparam int HOLD_CYC    = HOLDOFF_US * CLK_MHZ;
    localparam int RESP_CYC    = T_RESP_US * CLK_MHZ;
    localparam int ACK_CYC     = T_ACK_US * CLK_MHZ;
    localparam int BITLOW_CYC  = T_BITLOW_US * CLK_MHZ;
    localparam int BITHIGH_CYC = T_BITHIGH_US * CLK_MHZ;
    localparam int THRESH_CYC  = ONE_THRESH_US * CLK_MHZ;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(START_CYC, HOLD_CYC), max2(RESP_CYC, ACK_CYC)),
                                  max2(max2(BITLOW_CYC, BITHIGH_CYC), THRESH_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RESP_LAST    = CNT_W'(RESP_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_CYC - 1);
    localparam logic [CNT_W-1:0] BITLOW_LAST  = CNT_W'(BITLOW_CYC - 1);
    localparam logic [CNT_W-1:0] BITHIGH_LAST = CNT_W'(BITHIGH_CYC - 1);
    localparam logic [CNT_W-1:0] THRESH       = CNT_W'(THRESH_CYC);
    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_BITS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_RESP, S_ACK_LOW, S_ACK_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_HOLDOFF
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CNT_W-1:0]     phase_cnt_q, phase_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 start_lat_q, start_lat_d;
    logic                 wire_oe_q, wire_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic [2:0]           err_q, err_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;

    logic                 wire_s;
    logic                 sum_ok;
    logic                 fail;
    logic [2:0]           fail_code;

    assign wire_s = sync_q[1];

    generate
        if (CHECKSUM_EN != 0 && DATA_BITS == 40) begin : g_sum
            logic [7:0] byte_sum;
            assign byte_sum = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
            assign sum_ok   = (byte_sum == shift_q[7:0]);
        end else begin : g_nosum
            assign sum_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[0], wire_in};
        phase_cnt_d = phase_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        start_lat_d = start_lat_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        err_d       = err_q;
        out_data_d  = out_data_q;
        fail        = 1'b0;
        fail_code   = 3'd0;

        case (state_q)
            S_IDLE: begin
                phase_cnt_d = '0;
                if (start) begin
                    state_d   = S_START_LOW;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            S_START_LOW: begin
                if (phase_cnt_q == START_LAST) state_d = S_RESP;
            end
            S_RESP: begin
                if (!wire_s)                        state_d = S_ACK_LOW;
                else if (phase_cnt_q == RESP_LAST) begin fail = 1'b1; fail_code = 3'd1; end
            end
            S_ACK_LOW: begin
                if (wire_s)                         state_d = S_ACK_HIGH;
                else if (phase_cnt_q == ACK_LAST)  begin fail = 1'b1; fail_code = 3'd2; end
            end
            S_ACK_HIGH: begin
                if (!wire_s)                        state_d = S_BIT_LOW;
                else if (phase_cnt_q == ACK_LAST)  begin fail = 1'b1; fail_code = 3'd3; end
            end
            S_BIT_LOW: begin
                if (wire_s)                          state_d = S_BIT_HIGH;
                else if (phase_cnt_q == BITLOW_LAST) begin fail = 1'b1; fail_code = 3'd4; end
            end
            S_BIT_HIGH: begin
                // counter holds (high cycles - 1) when the falling edge is seen
                if (!wire_s) begin
                    shift_d   = {shift_q[DATA_BITS-2:0], (phase_cnt_q >= THRESH)};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? S_CHECK : S_BIT_LOW;
                end else if (phase_cnt_q == BITHIGH_LAST) begin
                    fail      = 1'b1;
                    fail_code = 3'd5;
                end
            end
            S_CHECK: begin
                done_d  = 1'b1;
                state_d = S_HOLDOFF;
                if (sum_ok) begin
                    err_d      = 3'd0;
                    valid_d    = 1'b1;
                    out_data_d = shift_q;
                end else begin
                    err_d   = 3'd6;
                    valid_d = 1'b0;
                end
            end
            S_HOLDOFF: begin
                if (start) start_lat_d = 1'b1;
                if (phase_cnt_q == HOLD_LAST) begin
                    start_lat_d = 1'b0;
                    if (start_lat_q || start) begin
                        state_d   = S_START_LOW;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d = S_HOLDOFF;
            done_d  = 1'b1;
            valid_d = 1'b0;
            err_d   = fail_code;
        end
        if (state_d != state_q) phase_cnt_d = '0;
    end

    assign wire_oe_d = (state_d == S_START_LOW);
    assign busy_d    = (state_d != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            phase_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            start_lat_q <= 1'b0;
            wire_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 3'd0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            phase_cnt_q <= phase_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            start_lat_q <= start_lat_d;
            wire_oe_q   <= wire_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
        end
    end

    assign wire_oe  = wire_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign out_data = out_data_q;

endmodule
